// File: rtl/dfd_cla_pkg.sv
// rtl/dfd_cla_pkg.sv - shared types for the CLA counter control path
package dfd_cla_pkg;

    localparam int CLA_NUM_COUNTERS = 4;

    typedef enum logic [2:0] {
        CLA_OP_NOP         = 3'd0,
        CLA_OP_INC_PULSE   = 3'd1,
        CLA_OP_START_AUTO  = 3'd2,
        CLA_OP_STOP_AUTO   = 3'd3,
        CLA_OP_CLEAR       = 3'd4,
        CLA_OP_CLEAR_START = 3'd5,
        CLA_OP_RSVD6       = 3'd6,
        CLA_OP_RSVD7       = 3'd7
    } cla_ctr_op_e;

    // One-hot command bundle consumed by a dfd_cla_counter instance
    typedef struct packed {
        logic clear_ctr;
        logic stop_auto_increment;
        logic auto_increment;
        logic increment_pulse;
    } counter_controls_t;

endpackage

// File: rtl/dfd_cla_counter_ctrl_slice.sv
// rtl/dfd_cla_counter_ctrl_slice.sv - per-counter priority merge, shadow, pending and resume state
module dfd_cla_counter_ctrl_slice
    import dfd_cla_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_pulse,
    input  logic              req_start,
    input  logic              req_stop,
    input  logic              req_clear,
    input  logic              req_clear_start,
    input  logic              freeze,
    input  logic              freeze_q,
    output counter_controls_t controls,
    output logic              auto_active,
    output logic              pending_start
);

    logic              resume_mask;
    logic              freeze_rise;
    logic              freeze_fall;
    logic              want_start;
    logic              auto_next;
    logic              pending_next;
    logic              resume_next;
    counter_controls_t controls_next;

    assign freeze_rise = freeze & ~freeze_q;
    assign freeze_fall = ~freeze & freeze_q;
    // A queued start and a freeze resume both behave like a START request
    assign want_start  = req_start | pending_start | (freeze_fall & resume_mask);

    always_comb begin
        controls_next = '0;
        auto_next     = auto_active;
        pending_next  = 1'b0;
        resume_next   = 1'b0;
        controls_next.clear_ctr = req_clear;
        if (freeze) begin
            controls_next.stop_auto_increment = freeze_rise & auto_active & ~req_clear;
            auto_next   = 1'b0;
            resume_next = req_clear_start |
                          (~req_stop & (freeze_rise ? (auto_active | pending_start) : resume_mask));
        end else begin
            controls_next.stop_auto_increment = ~req_clear & req_stop & auto_active;
            controls_next.auto_increment      = ~req_clear & ~req_stop & want_start & ~auto_active;
            controls_next.increment_pulse     = ~req_clear & ~req_stop & ~want_start &
                                                req_pulse & ~auto_active;
            if (req_clear || req_stop) begin
                auto_next = 1'b0;
            end else if (want_start) begin
                auto_next = 1'b1;
            end
            pending_next = req_clear & (req_clear_start | (pending_start & ~req_stop));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            controls      <= '0;
            auto_active   <= 1'b0;
            pending_start <= 1'b0;
            resume_mask   <= 1'b0;
        end else begin
            controls      <= controls_next;
            auto_active   <= auto_next;
            pending_start <= pending_next;
            resume_mask   <= resume_next;
        end
    end

endmodule

// File: rtl/dfd_cla_counter_ctrl.sv
// rtl/dfd_cla_counter_ctrl.sv - decodes CLA action slots into per-counter command pulses
module dfd_cla_counter_ctrl
    import dfd_cla_pkg::*;
#(
    parameter int NUM_COUNTERS = CLA_NUM_COUNTERS,
    parameter int NUM_ACTIONS  = 2,
    localparam int CNT_IDX_W   = $clog2(NUM_COUNTERS),
    localparam int ACTION_W    = 3 + CNT_IDX_W
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    input  logic [NUM_ACTIONS-1:0]                   action_valid,
    input  logic [NUM_ACTIONS-1:0][ACTION_W-1:0]     action_code,
    input  logic [NUM_COUNTERS-1:0]                  sw_clear,
    input  logic                                     freeze,
    output counter_controls_t [NUM_COUNTERS-1:0]     cla_counter_controls,
    output logic [NUM_COUNTERS-1:0]                  auto_active,
    output logic [NUM_COUNTERS-1:0]                  pending_start
);

    logic                    freeze_q;
    logic [NUM_COUNTERS-1:0] req_pulse;
    logic [NUM_COUNTERS-1:0] req_start;
    logic [NUM_COUNTERS-1:0] req_stop;
    logic [NUM_COUNTERS-1:0] req_clear;
    logic [NUM_COUNTERS-1:0] req_clear_start;

    always_comb begin
        req_pulse       = '0;
        req_start       = '0;
        req_stop        = '0;
        req_clear       = sw_clear;
        req_clear_start = '0;
        for (int s = 0; s < NUM_ACTIONS; s++) begin
            if (action_valid[s]) begin
                case (cla_ctr_op_e'(action_code[s][ACTION_W-1:CNT_IDX_W]))
                    CLA_OP_INC_PULSE:  req_pulse[action_code[s][CNT_IDX_W-1:0]] = 1'b1;
                    CLA_OP_START_AUTO: req_start[action_code[s][CNT_IDX_W-1:0]] = 1'b1;
                    CLA_OP_STOP_AUTO:  req_stop[action_code[s][CNT_IDX_W-1:0]]  = 1'b1;
                    CLA_OP_CLEAR:      req_clear[action_code[s][CNT_IDX_W-1:0]] = 1'b1;
                    CLA_OP_CLEAR_START: begin
                        req_clear[action_code[s][CNT_IDX_W-1:0]]       = 1'b1;
                        req_clear_start[action_code[s][CNT_IDX_W-1:0]] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            freeze_q <= 1'b0;
        end else begin
            freeze_q <= freeze;
        end
    end

    for (genvar c = 0; c < NUM_COUNTERS; c++) begin : g_slice
        dfd_cla_counter_ctrl_slice u_slice (
            .clock           (clock),
            .reset_n         (reset_n),
            .req_pulse       (req_pulse[c]),
            .req_start       (req_start[c]),
            .req_stop        (req_stop[c]),
            .req_clear       (req_clear[c]),
            .req_clear_start (req_clear_start[c]),
            .freeze          (freeze),
            .freeze_q        (freeze_q),
            .controls        (cla_counter_controls[c]),
            .auto_active     (auto_active[c]),
            .pending_start   (pending_start[c])
        );
    end

endmodule

// File: tb/tb_dfd_cla_counter_ctrl.sv
// tb/tb_dfd_cla_counter_ctrl.sv - scoreboard bench for the CLA counter control stage
module tb_dfd_cla_counter_ctrl;
    import dfd_cla_pkg::*;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic [1:0]             action_valid = '0;
    logic [1:0][4:0]        action_code = '0;
    logic [3:0]             sw_clear = '0;
    logic                   freeze = 1'b0;
    counter_controls_t [3:0] ctl;
    logic [3:0]             auto_active;
    logic [3:0]             pending_start;

    always #5 clock = ~clock;

    dfd_cla_counter_ctrl #(.NUM_COUNTERS(4), .NUM_ACTIONS(2)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .action_valid         (action_valid),
        .action_code          (action_code),
        .sw_clear             (sw_clear),
        .freeze               (freeze),
        .cla_counter_controls (ctl),
        .auto_active          (auto_active),
        .pending_start        (pending_start)
    );

    typedef struct packed {
        logic [15:0] ctl;
        logic [3:0]  aa;
        logic [3:0]  ps;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: what each counter is doing, what is queued, what resumes after freeze
    bit m_auto[4];
    bit m_pend[4];
    bit m_res[4];
    bit m_fq;

    localparam int CMD_NONE = 0, CMD_PULSE = 1, CMD_AUTO = 2, CMD_STOP = 3, CMD_CLEAR = 4;

    task automatic step(input logic rst, input logic [1:0] v,
                        input logic [2:0] op0, input logic [1:0] i0,
                        input logic [2:0] op1, input logic [1:0] i1,
                        input logic [3:0] sw, input logic frz);
        exp_t e;
        int   cmd;
        bit   hit[8];
        bit   clr, cs, stp, sta, pul, rise, start;
        bit   n_auto, n_pend, n_res;
        logic [2:0] ops[2];
        logic [1:0] idx[2];
        @(negedge clock);
        reset_n        = rst;
        action_valid   = v;
        action_code[0] = {op0, i0};
        action_code[1] = {op1, i1};
        sw_clear       = sw;
        freeze         = frz;
        ops[0] = op0; ops[1] = op1; idx[0] = i0; idx[1] = i1;
        e = '0;
        rise = frz && !m_fq;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 8; k++) hit[k] = 0;
            for (int s = 0; s < 2; s++)
                if (v[s] && idx[s] == c[1:0]) hit[ops[s]] = 1;
            clr = sw[c] || hit[4] || hit[5];
            cs  = hit[5];
            stp = hit[3];
            sta = hit[2];
            pul = hit[1];
            cmd = CMD_NONE;
            n_auto = m_auto[c]; n_pend = 0; n_res = 0;
            if (!rst) begin
                n_auto = 0;
            end else if (frz) begin
                if (clr) cmd = CMD_CLEAR;
                else if (rise && m_auto[c]) cmd = CMD_STOP;
                if (cs) n_res = 1;
                else if (stp) n_res = 0;
                else n_res = rise ? (m_auto[c] || m_pend[c]) : m_res[c];
                n_auto = 0;
            end else begin
                start = sta || m_pend[c] || (m_fq && m_res[c]);
                if (clr) begin
                    cmd = CMD_CLEAR;
                    n_auto = 0;
                    n_pend = cs || (m_pend[c] && !stp);
                end else if (stp) begin
                    if (m_auto[c]) cmd = CMD_STOP;
                    n_auto = 0;
                end else if (start) begin
                    if (!m_auto[c]) cmd = CMD_AUTO;
                    n_auto = 1;
                end else if (pul) begin
                    if (!m_auto[c]) cmd = CMD_PULSE;
                end
            end
            case (cmd)
                CMD_CLEAR: e.ctl[c*4 +: 4] = 4'b1000;
                CMD_STOP:  e.ctl[c*4 +: 4] = 4'b0100;
                CMD_AUTO:  e.ctl[c*4 +: 4] = 4'b0010;
                CMD_PULSE: e.ctl[c*4 +: 4] = 4'b0001;
                default:   e.ctl[c*4 +: 4] = 4'b0000;
            endcase
            m_auto[c] = n_auto; m_pend[c] = n_pend; m_res[c] = n_res;
            e.aa[c] = n_auto;
            e.ps[c] = n_pend;
        end
        m_fq = rst ? frz : 1'b0;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input logic frz);
        for (int k = 0; k < n; k++) step(1, 2'b00, 3'd0, 2'd0, 3'd0, 2'd0, 4'h0, frz);
    endtask

    // Monitor: the DUT presents a fresh bundle after every clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (ctl !== e.ctl) begin
                    fails++;
                    $display("FAIL controls t=%0t got=%h want=%h", $time, ctl, e.ctl);
                end
                tests++;
                if (auto_active !== e.aa) begin
                    fails++;
                    $display("FAIL auto_active t=%0t got=%b want=%b", $time, auto_active, e.aa);
                end
                tests++;
                if (pending_start !== e.ps) begin
                    fails++;
                    $display("FAIL pending_start t=%0t got=%b want=%b", $time, pending_start, e.ps);
                end
            end
        end
    end

    initial begin
        logic [1:0] rv;
        logic [2:0] ro0, ro1;
        logic [1:0] ri0, ri1;
        logic [3:0] rsw;
        logic       rfrz;
        logic       rrst;
        for (int c = 0; c < 4; c++) begin
            m_auto[c] = 0; m_pend[c] = 0; m_res[c] = 0;
        end
        m_fq = 0;
        for (int k = 0; k < 3; k++) step(0, 2'b00, 3'd0, 2'd0, 3'd0, 2'd0, 4'h0, 1'b0);
        idle(2, 1'b0);
        step(1, 2'b01, CLA_OP_START_AUTO, 2'd1, 3'd0, 2'd0, 4'h0, 1'b0);
        idle(1, 1'b0);
        step(1, 2'b01, CLA_OP_START_AUTO, 2'd1, 3'd0, 2'd0, 4'h0, 1'b0);
        step(1, 2'b11, CLA_OP_INC_PULSE, 2'd2, CLA_OP_CLEAR, 2'd2, 4'h0, 1'b0);
        step(1, 2'b01, CLA_OP_CLEAR_START, 2'd0, 3'd0, 2'd0, 4'h0, 1'b0);
        step(1, 2'b01, CLA_OP_STOP_AUTO, 2'd0, 3'd0, 2'd0, 4'h0, 1'b0);
        idle(2, 1'b0);
        step(1, 2'b01, CLA_OP_CLEAR_START, 2'd0, 3'd0, 2'd0, 4'h0, 1'b0);
        step(1, 2'b01, CLA_OP_CLEAR, 2'd0, 3'd0, 2'd0, 4'h0, 1'b0);
        idle(2, 1'b0);
        step(1, 2'b01, CLA_OP_START_AUTO, 2'd3, 3'd0, 2'd0, 4'h0, 1'b0);
        step(1, 2'b01, CLA_OP_STOP_AUTO, 2'd1, 3'd0, 2'd0, 4'h0, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);
        step(1, 2'b01, CLA_OP_STOP_AUTO, 2'd3, 3'd0, 2'd0, 4'h0, 1'b1);
        step(1, 2'b01, CLA_OP_INC_PULSE, 2'd1, 3'd0, 2'd0, 4'h0, 1'b1);
        step(1, 2'b00, 3'd0, 2'd0, 3'd0, 2'd0, 4'h2, 1'b1);
        step(1, 2'b01, CLA_OP_CLEAR_START, 2'd2, 3'd0, 2'd0, 4'h0, 1'b1);
        idle(2, 1'b1);
        idle(3, 1'b0);
        step(1, 2'b01, CLA_OP_CLEAR, 2'd0, 3'd0, 2'd0, 4'h0, 1'b1);
        idle(2, 1'b0);
        step(1, 2'b01, CLA_OP_CLEAR_START, 2'd0, 3'd0, 2'd0, 4'h0, 1'b0);
        step(0, 2'b00, 3'd0, 2'd0, 3'd0, 2'd0, 4'h0, 1'b0);
        idle(3, 1'b0);
        rfrz = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rv   = 2'($urandom_range(0, 3));
            ro0  = 3'($urandom_range(0, 7));
            ro1  = 3'($urandom_range(0, 7));
            ri0  = 2'($urandom_range(0, 3));
            ri1  = 2'($urandom_range(0, 3));
            rsw  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if ($urandom_range(0, 15) == 0) rfrz = ~rfrz;
            rrst = ($urandom_range(0, 199) != 0);
            step(rrst, rv, ro0, ri0, ro1, ri1, rsw, rfrz);
        end
        idle(2, 1'b0);
        repeat (3) @(posedge clock);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dfd_cla_counter_ctrl.md
Name: dfd_cla_counter_ctrl

Overview:
Upstream control stage for the CLA counters. Decodes action codes issued by the CLA trigger/state logic and software clear requests into one registered counter_controls pulse bundle per counter. Each bundle drives one dfd_cla_counter instance. The block keeps a shadow of each counter's auto-increment state and implements freeze/resume and clear-then-start sequencing, so the counter FSMs only receive legal, non-conflicting commands.

Parameters:
NUM_COUNTERS, 4, number of counters driven; power of 2, minimum 2.
NUM_ACTIONS, 2, number of action slots the CLA can issue per cycle.
CNT_IDX_W (localparam), $clog2(NUM_COUNTERS), width of the counter index field.
ACTION_W (localparam), 3+CNT_IDX_W, width of an action code: {op[2:0], idx}.

Ports:
clock  in  1  clock.
reset_n  in  1  synchronous reset, active-low.
action_valid  in  NUM_ACTIONS  per-slot valid qualifier.
action_code  in  NUM_ACTIONS x ACTION_W  per-slot {op, counter index}.
sw_clear  in  NUM_COUNTERS  software clear request, one bit per counter.
freeze  in  1  debug freeze level.
cla_counter_controls  out  NUM_COUNTERS x counter_controls  registered per-counter command pulses.
auto_active  out  NUM_COUNTERS  shadow auto-increment state.
pending_start  out  NUM_COUNTERS  start queued behind a clear.

Behaviour:
- Reset: all cla_counter_controls fields = 0; auto_active, pending_start, resume_mask, freeze_q = 0.
- Op encoding:
  - 0 NOP.
  - 1 INC_PULSE.
  - 2 START_AUTO.
  - 3 STOP_AUTO.
  - 4 CLEAR.
  - 5 CLEAR_START.
  - 6 and 7 reserved; treat as NOP.
  - Slots with action_valid=0 are ignored.
- Latency: actions sampled in cycle N; control pulses visible in cycle N+1, held for exactly one cycle.
- Per-counter merge: OR requests across all slots and sw_clear. Priority is clear > stop > start > pulse. At most one control bit is set per counter per cycle.
- Shadow state:
  - Emitted auto_increment sets auto_active.
  - Emitted clear_ctr or stop_auto_increment clears auto_active.
- Redundancy suppression:
  - START_AUTO with auto_active=1 emits nothing.
  - STOP_AUTO with auto_active=0 emits nothing.
  - INC_PULSE with auto_active=1 emits nothing.
- CLEAR_START: emit clear_ctr in N+1 and set pending_start. In N+2 emit auto_increment and clear pending_start, unless a clear/stop arrived in N+1 or freeze is high.
  - A stop cancels pending_start.
  - A new clear keeps it pending.
- Freeze:
  - Rising edge (freeze & ~freeze_q): emit stop_auto_increment for every counter with auto_active. Copy auto_active | pending_start into resume_mask; clear pending_start.
  - While frozen: INC_PULSE and START_AUTO are dropped. STOP_AUTO clears the resume_mask bit. CLEAR and sw_clear emit clear_ctr and leave resume_mask unchanged. CLEAR_START emits clear_ctr and sets the resume_mask bit.
  - Falling edge: emit auto_increment for resume_mask counters, then zero resume_mask. Actions sampled in the same cycle as the falling edge merge under normal priority, with resume treated as a start.
- Same-cycle freeze rising edge plus clear for the same counter: clear wins; the resume_mask bit is still recorded.
- Out-of-range index is impossible by construction, since NUM_COUNTERS is a power of 2.
- Reset mid-operation: all state drops to reset values next clock; no pending command survives.

Decomposition:
- dfd_cla_pkg: action op enum (cla_ctr_op_e), existing counter_controls struct, CLA_NUM_COUNTERS default.
- Sub-module dfd_cla_counter_ctrl_slice: per-counter merge/priority, shadow, pending and resume logic; generated NUM_COUNTERS times.
- The top level decodes the slots into per-counter request vectors and holds freeze_q.

Test Plan:
- Slot0 START_AUTO idx1 in cycle 10 → counter1.auto_increment=1 in cycle 11 only; auto_active[1]=1 from cycle 11; repeat START in cycle 12 → no output.
- Same cycle: slot0 INC_PULSE idx2, slot1 CLEAR idx2 → only clear_ctr[2]=1 next cycle; increment_pulse[2]=0.
- CLEAR_START idx0 in cycle 5 → clear_ctr[0] in cycle 6, auto_increment[0] in cycle 7; with STOP_AUTO idx0 in cycle 6 → no start in cycle 7, pending_start[0]=0.
- Counters 0 and 3 active; freeze rises in cycle 20 → stop_auto_increment on 0 and 3 in cycle 21; STOP_AUTO idx3 in cycle 25; freeze falls in cycle 30 → auto_increment[0] only in cycle 31.
- During freeze, INC_PULSE idx1 → no output; sw_clear[1] → clear_ctr[1] next cycle.
- reset_n low in cycle 6 with pending_start[0]=1 → all outputs 0 from cycle 7; no auto_increment ever issued.
